// File: rtl/rhd_pkg.sv
// Shared constants for the RHD2000-style SPI responder: opcodes, special command words, ROM map.
// No timing or flow control of its own.
package rhd_pkg;

  localparam logic [1:0] CMD_CONVERT = 2'b00;
  localparam logic [1:0] CMD_CALCLR  = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;
  localparam logic [1:0] CMD_READ    = 2'b11;

  localparam logic [15:0] CALIBRATE_WORD = 16'h5500;
  localparam logic [15:0] CLEAR_WORD     = 16'h6A00;

  localparam int         NUM_REGS     = 22;
  localparam int         TWOSCOMP_REG = 4;
  localparam int         TWOSCOMP_BIT = 6;
  localparam logic [7:0] WRITE_ECHO   = 8'hFF;

  localparam logic [5:0] ROM_INTAN_BASE   = 6'd40;
  localparam logic [5:0] ROM_DIE_REV      = 6'd60;
  localparam logic [5:0] ROM_UNIPOLAR     = 6'd61;
  localparam logic [5:0] ROM_NUM_AMPS     = 6'd62;
  localparam logic [5:0] ROM_CHIP_ID      = 6'd63;
  localparam logic [7:0] ROM_DIE_REV_VAL  = 8'h01;
  localparam logic [7:0] ROM_UNIPOLAR_VAL = 8'h01;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_COMMIT} state_t;

  // Characters of the "INTAN" company string held at ROM_INTAN_BASE..+4.
  function automatic logic [7:0] intan_char(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h49;
      3'd1:    return 8'h4E;
      3'd2:    return 8'h54;
      3'd3:    return 8'h41;
      3'd4:    return 8'h4E;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rhd_sync_edge.sv
// 2-FF synchronizer with rise/fall pulses; pulses appear 2 clk after the input changes.
// No backpressure: one pulse per input transition.
module rhd_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] sh;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sh <= {3{RST_VAL}};
    else       sh <= {sh[1:0], d};
  end

  assign level = sh[1];
  assign rise  = sh[1] & ~sh[2];
  assign fall  = ~sh[1] & sh[2];

endmodule

// File: rtl/rhd_spi_target.sv
// RHD2164-style SPI responder: 16-bit command frames in, results out on MISO two frames later.
// Acts 3 clk after each synchronized SPI edge; no backpressure, malformed frames are dropped.
module rhd_spi_target
  import rhd_pkg::*;
#(
  parameter logic [15:0] STARTING_SEED = 16'd0,
  parameter int          CHIP_ID       = 4,
  parameter int          NUM_AMPS      = 64
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       SCLK,
  input  logic       MOSI,
  input  logic       CS,
  output logic       MISO,
  output logic [7:0] channel_out,
  output logic       frame_done,
  output logic       frame_error
);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_lvl;
  logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

  rhd_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rstn(rstn), .d(SCLK), .level(unused_sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  rhd_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rstn(rstn), .d(CS), .level(unused_cs_lvl), .rise(cs_rise), .fall(cs_fall));
  rhd_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rstn(rstn), .d(MOSI), .level(mosi_lvl), .rise(unused_mosi_rise), .fall(unused_mosi_fall));

  state_t      state;
  logic [15:0] rx, tx, pipe1, pipe2, sweep;
  logic [4:0]  bitcnt;
  logic        cs_fall_pend;
  logic [7:0]  regs [NUM_REGS];

  logic [1:0]  cmd_op;
  logic [5:0]  cmd_arg;
  logic        chan_valid, chan_last;
  logic [15:0] sample, result;
  logic [7:0]  read_val;
  logic        unused_calclr_hit;

  assign cmd_op     = rx[15:14];
  assign cmd_arg    = rx[13:8];
  assign chan_valid = {26'd0, cmd_arg} < NUM_AMPS;
  assign chan_last  = {26'd0, cmd_arg} == NUM_AMPS - 1;
  assign sample     = STARTING_SEED + {10'd0, cmd_arg} + sweep;
  // Calibrate/clear have no analog side effects here; the decode only aids waveform debug.
  assign unused_calclr_hit = (rx == CALIBRATE_WORD) || (rx == CLEAR_WORD);

  always_comb begin
    read_val = 8'h00;
    if (cmd_arg < 6'(NUM_REGS)) begin
      read_val = regs[cmd_arg[4:0]];
    end else if (cmd_arg >= ROM_INTAN_BASE && cmd_arg < ROM_INTAN_BASE + 6'd5) begin
      read_val = intan_char(3'(cmd_arg - ROM_INTAN_BASE));
    end else begin
      case (cmd_arg)
        ROM_DIE_REV:  read_val = ROM_DIE_REV_VAL;
        ROM_UNIPOLAR: read_val = ROM_UNIPOLAR_VAL;
        ROM_NUM_AMPS: read_val = 8'(NUM_AMPS);
        ROM_CHIP_ID:  read_val = 8'(CHIP_ID);
        default:      read_val = 8'h00;
      endcase
    end
  end

  always_comb begin
    result = 16'h0000;
    case (cmd_op)
      CMD_CONVERT: if (chan_valid)
                     result = regs[TWOSCOMP_REG][TWOSCOMP_BIT] ? (sample ^ 16'h8000) : sample;
      CMD_CALCLR:  result = 16'h0000;
      CMD_WRITE:   result = {WRITE_ECHO, rx[7:0]};
      CMD_READ:    result = {8'h00, read_val};
      default:     result = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      MISO         <= 1'b0;
      channel_out  <= 8'h00;
      frame_done   <= 1'b0;
      frame_error  <= 1'b0;
      rx           <= 16'h0000;
      tx           <= 16'h0000;
      pipe1        <= 16'h0000;
      pipe2        <= 16'h0000;
      sweep        <= 16'h0000;
      bitcnt       <= 5'd0;
      cs_fall_pend <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else begin
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        ST_IDLE: begin
          MISO <= 1'b0;
          if (cs_fall || cs_fall_pend) begin
            cs_fall_pend <= 1'b0;
            bitcnt       <= 5'd0;
            tx           <= pipe2;
            MISO         <= pipe2[15];
            state        <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // A CS edge in the same clk as an SCLK edge takes priority.
          if (cs_rise) begin
            MISO  <= 1'b0;
            state <= ST_COMMIT;
          end else if (sclk_rise) begin
            rx <= {rx[14:0], mosi_lvl};
            if (bitcnt != 5'd17) bitcnt <= bitcnt + 5'd1;
          end else if (sclk_fall) begin
            tx   <= {tx[14:0], 1'b0};
            MISO <= tx[14];
          end
        end
        ST_COMMIT: begin
          state        <= ST_IDLE;
          cs_fall_pend <= cs_fall;
          if (bitcnt == 5'd16) begin
            pipe2      <= pipe1;
            pipe1      <= result;
            frame_done <= 1'b1;
            case (cmd_op)
              CMD_CONVERT: begin
                channel_out <= {2'b00, cmd_arg};
                if (chan_last) sweep <= sweep + 16'd1;
              end
              CMD_WRITE: if (cmd_arg < 6'(NUM_REGS)) regs[cmd_arg[4:0]] <= rx[7:0];
              default: ;
            endcase
          end else begin
            frame_error <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
